// File: rtl/sync_fifo_burst_reader.sv
// Read-side burst controller for the synchronous FIFO: issues bursts of reads, absorbs the
// 1-cycle read latency in a 2-entry skid buffer and emits a valid/ready stream with a last marker.
// Optional feature macro: BURST_TIMEOUT_EN (auto partial burst after TIMEOUT_CYC idle cycles).
module sync_fifo_burst_reader #(
  parameter int FIFO_PTR    = 4,
  parameter int FIFO_WIDTH  = 8,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rstb,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rden,
  input  logic                  flush_req,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [FIFO_PTR:0] BURST_LEN_W = (FIFO_PTR+1)'(BURST_LEN);
  localparam logic [FIFO_PTR:0] ONE_W       = (FIFO_PTR+1)'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_BURST  = 2'd1,
    WAIT_LAST = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [FIFO_PTR:0]               beats_left_q, beats_left_d;
  logic                            inflight_q, inflight_last_q;
  logic [1:0]                      buf_count_q, buf_count_d;
  logic [1:0][FIFO_WIDTH-1:0]      buf_data_q, buf_data_d;
  logic [1:0]                      buf_last_q, buf_last_d;
  logic                            pop;
  logic                            push;
  logic [1:0]                      wr_slot;
  logic [2:0]                      occupancy;
  logic                            timeout_hit;

  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;
  assign occupancy = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign out_valid = (buf_count_q != 2'd0);
  assign out_data  = buf_data_q[0];
  assign out_last  = buf_last_q[0];
  assign busy      = (state_q != IDLE);

`ifdef BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TIMEOUT_W = TW'(TIMEOUT_CYC);

  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (idle_cnt_q == TIMEOUT_W);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (state_q != IDLE || fifo_data_avail == '0) begin
      idle_cnt_d = '0;
    end else if (fifo_data_avail < BURST_LEN_W && !timeout_hit) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_rstb) begin
    if (!fifo_rstb) idle_cnt_q <= '0;
    else            idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    fifo_rden    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_data_avail >= BURST_LEN_W) begin
          state_d      = RD_BURST;
          beats_left_d = BURST_LEN_W;
        end else if ((flush_req || timeout_hit) && !fifo_empty && fifo_data_avail != '0) begin
          state_d      = RD_BURST;
          beats_left_d = fifo_data_avail;
        end
      end
      RD_BURST: begin
        // Count the beat already in flight so the skid buffer can never be overrun.
        fifo_rden = (beats_left_q != '0) && !fifo_empty && (occupancy < 3'd2);
        if (fifo_rden) begin
          beats_left_d = beats_left_q - ONE_W;
          if (beats_left_q == ONE_W) state_d = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (!inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Head is always slot 0; a new beat lands just behind whatever survives this cycle's pop.
  assign wr_slot = buf_count_q - {1'b0, pop};

  always_comb begin
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_count_d = buf_count_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
    end
    if (push) begin
      buf_data_d[wr_slot[0]] = fifo_rddata;
      buf_last_d[wr_slot[0]] = inflight_last_q;
    end
  end

  always_ff @(posedge fifo_clk or negedge fifo_rstb) begin
    if (!fifo_rstb) begin
      state_q         <= IDLE;
      beats_left_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_count_q     <= '0;
      buf_data_q      <= '0;
      buf_last_q      <= '0;
    end else begin
      state_q         <= state_d;
      beats_left_q    <= beats_left_d;
      inflight_q      <= fifo_rden;
      inflight_last_q <= fifo_rden && (beats_left_q == ONE_W);
      buf_count_q     <= buf_count_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
    end
  end

  a_no_underflow: assert property (@(posedge fifo_clk) disable iff (!fifo_rstb)
    !(fifo_rden && fifo_empty));

  a_skid_bound: assert property (@(posedge fifo_clk) disable iff (!fifo_rstb)
    ({1'b0, buf_count_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Directed bench for sync_fifo_burst_reader with a behavioural 16-entry FIFO on its read port.
module tb_sync_fifo_burst_reader;
  localparam int PTR = 4;
  localparam int W   = 8;
  localparam int BL  = 8;

  logic           clk = 1'b0;
  logic           rstb = 1'b0;
  logic [PTR:0]   avail;
  logic           empty;
  logic [W-1:0]   rddata;
  logic           rden;
  logic           flush = 1'b0;
  logic           ovalid;
  logic           oready = 1'b0;
  logic [W-1:0]   odata;
  logic           olast;
  logic           busy;

  logic           wr_en = 1'b0;
  logic [W-1:0]   wr_data = '0;
  logic [W-1:0]   mem [16];
  logic [PTR-1:0] wp, rp;

  int total = 0, bad = 0;
  int rden_cnt = 0, run_cur = 0, uflow = 0;
  int run_q[$];
  logic [8:0] beat_q[$];

  sync_fifo_burst_reader #(
    .FIFO_PTR(PTR), .FIFO_WIDTH(W), .BURST_LEN(BL), .TIMEOUT_CYC(64)
  ) dut (
    .fifo_clk(clk), .fifo_rstb(rstb), .fifo_data_avail(avail), .fifo_empty(empty),
    .fifo_rddata(rddata), .fifo_rden(rden), .flush_req(flush), .out_valid(ovalid),
    .out_ready(oready), .out_data(odata), .out_last(olast), .busy(busy)
  );

  always #5 clk = ~clk;

  assign empty = (avail == '0);

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wp <= '0; rp <= '0; avail <= '0; rddata <= '0;
    end else begin
      if (wr_en) begin mem[wp] <= wr_data; wp <= wp + 1'b1; end
      if (rden)  begin rddata <= mem[rp]; rp <= rp + 1'b1; end
      avail <= avail + {4'b0, wr_en} - {4'b0, rden};
    end
  end

  always @(negedge clk) begin
    if (rden) begin
      rden_cnt++;
      run_cur++;
      if (empty) uflow++;
    end else if (run_cur != 0) begin
      run_q.push_back(run_cur);
      run_cur = 0;
    end
    if (ovalid && oready) beat_q.push_back({olast, odata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qbeat(input int i);
    return (i < beat_q.size()) ? {23'b0, beat_q[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int qrun(input int i);
    return (i < run_q.size()) ? run_q[i] : -1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    beat_q.delete();
    run_q.delete();
    run_cur  = 0;
    rden_cnt = 0;
  endtask

  task automatic push_n(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + 8'(i);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (beat_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, beat_q.size(), n);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [W-1:0] base,
                             input int blen);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), qbeat(i),
            {23'b0, ((i + 1) % blen == 0), 8'(base + 8'(i))});
  endtask

  initial begin
    int k;
    // reset state
    idle(3);
    check("rst_rden", rden, 0);
    check("rst_valid", ovalid, 0);
    check("rst_data", odata, 0);
    check("rst_last", olast, 0);
    check("rst_busy", busy, 0);
    rstb = 1'b1;
    idle(2);

    // two back-to-back full bursts at full throughput
    clr();
    oready = 1'b1;
    push_n(16, 8'h10);
    wait_beats("t2_nbeats", 16, 200);
    idle(6);
    check("t2_nruns", run_q.size(), 2);
    check("t2_run0", qrun(0), 8);
    check("t2_run1", qrun(1), 8);
    check_beats("t2", 16, 8'h10, 8);
    check("t2_avail", avail, 0);
    check("t2_busy", busy, 0);

    // backpressure: only two reads outstanding, head held stable
    clr();
    oready = 1'b0;
    push_n(8, 8'h30);
    idle(20);
    check("t3_rden_held", rden_cnt, 2);
    check("t3_valid", ovalid, 1);
    check("t3_hold0", {olast, odata}, {1'b0, 8'h30});
    idle(5);
    check("t3_hold1", odata, 8'h30);
    check("t3_nopop", beat_q.size(), 0);
    oready = 1'b1;
    wait_beats("t3_nbeats", 8, 60);
    idle(6);
    check_beats("t3", 8, 8'h30, 8);
    check("t3_rden_tot", rden_cnt, 8);
    check("t3_busy", busy, 0);

    // flush-driven partial burst, then flush on empty FIFO
    clr();
    push_n(3, 8'h50);
    idle(10);
    check("t4_no_auto", rden_cnt, 0);
    pulse_flush();
    wait_beats("t4_nbeats", 3, 50);
    idle(6);
    check_beats("t4", 3, 8'h50, 3);
    check("t4_avail", avail, 0);
    check("t4_busy", busy, 0);
    clr();
    pulse_flush();
    idle(10);
    check("t4_empty_flush", rden_cnt, 0);
    check("t4_empty_busy", busy, 0);

    // writes during a burst: second burst is exactly 8, one entry left over
    clr();
    push_n(17, 8'h70);
    wait_beats("t5_nbeats", 16, 200);
    idle(10);
    check("t5_nextra", beat_q.size(), 16);
    check("t5_nruns", run_q.size(), 2);
    check("t5_run0", qrun(0), 8);
    check("t5_run1", qrun(1), 8);
    check_beats("t5", 16, 8'h70, 8);
    check("t5_avail", avail, 1);
    check("t5_busy", busy, 0);
    pulse_flush();
    wait_beats("t5_drain_n", 17, 30);
    check("t5_drain", qbeat(16), {23'b0, 1'b1, 8'h80});

    // asynchronous reset in the middle of a burst
    clr();
    push_n(8, 8'hA0);
    k = 0;
    while (rden_cnt < 3 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("t1_started", 32'(rden_cnt >= 3), 1);
    #2;
    rstb = 1'b0;
    #1;
    check("t1_rden", rden, 0);
    check("t1_valid", ovalid, 0);
    check("t1_data", odata, 0);
    check("t1_last", olast, 0);
    check("t1_busy", busy, 0);
    idle(2);
    rstb = 1'b1;
    clr();
    idle(10);
    check("t1_nostale", beat_q.size(), 0);
    check("t1_norden", rden_cnt, 0);
    check("t1_valid_after", ovalid, 0);
    push_n(8, 8'hC0);
    wait_beats("t1_nbeats", 8, 60);
    idle(6);
    check_beats("t1", 8, 8'hC0, 8);

    // idle timeout
    clr();
    push_n(2, 8'hE0);
`ifdef BURST_TIMEOUT_EN
    idle(55);
    check("t6_early", rden_cnt, 0);
    wait_beats("t6_nbeats", 2, 60);
    idle(6);
    check_beats("t6", 2, 8'hE0, 2);
`else
    idle(100);
    check("t6_norden", rden_cnt, 0);
    check("t6_busy", busy, 0);
    check("t6_avail", avail, 2);
    pulse_flush();
    wait_beats("t6_nbeats", 2, 30);
    idle(6);
    check_beats("t6", 2, 8'hE0, 2);
`endif

    check("no_underflow", uflow, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
